mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit in the execute stage. It consumes the two source operands read by decode for MULT, MULTU, DIV and DIVU, and produces the 64-bit {HI, LO} result. That result is written back through the register file's HI/LO path, with write-data bits 63:32 going to HI and bits 31:0 to LO. While an operation is in flight the unit raises a stall so decode cannot read HI/LO early.

## Interface
Parameters:
- none; operand width fixed at 32, result width 64.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; accepted only in IDLE.
- op  input  2  operation select, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  32  rs operand (multiplicand or dividend), sampled with start.
- b  input  32  rt operand (multiplier or divisor), sampled with start.
- flush  input  1  abort any in-flight operation; no done is produced.
- busy  output  1  registered; high in every state except IDLE.
- stall  output  1  combinational: busy | (start & ~busy).
- done  output  1  registered one-cycle pulse; result is valid while high.
- result  output  64  registered {HI, LO}; holds its value between done pulses.

## Operation
- States: IDLE, PREP, RUN, FIX.
- IDLE:
  - start=1 captures op, a, b; next state is PREP.
  - start=0 stays in IDLE.
- PREP (1 cycle):
  - Forms 32-bit unsigned magnitudes of a and b; magnitudes are taken only for signed ops.
  - Records the result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Clears the accumulator and loads the iteration counter with 31.
  - Next state is RUN.
- RUN (32 cycles):
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - Divide: radix-2 restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - Counter decrements each cycle; at 0 the next state is FIX.
- FIX (1 cycle):
  - Applies two's-complement negation where the recorded signs require it.
  - Loads result, pulses done on the next cycle, and returns to IDLE.
- Multiply result: full 64-bit product.
- Divide result:
  - LO = quotient, truncated toward zero.
  - HI = remainder, which takes the dividend's sign.
- Divide by zero (b==0, DIV or DIVU): result = {a, 32'hFFFFFFFF}; latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0; no trap.
- start while busy: ignored; captured operands are unaffected.
- flush: from any state, next state is IDLE, done stays 0 and result is unchanged.
- flush and start in the same cycle: flush wins; start is ignored.
- Reset (asynchronous assertion, any state):
  - State returns to IDLE.
  - busy=0, done=0, result=0, counter=0; all internal registers are cleared.

## Timing
- Start accepted at edge E0: busy rises after E0.
- State sequence: PREP after E0, RUN from E1 to E33, FIX after E33.
- At E34: result loaded, done=1 and busy=0 for the cycle after E34.
- Latency: done asserts 34 cycles after the accepting edge.
- Back-to-back: a new start may be sampled in the same cycle done is high, because state is already IDLE.
- stall is high in the start cycle and every busy cycle; it is low in the done cycle.
- Reset release: start is honoured at the first rising edge after rst goes high.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> done at E0+34, result=0xFFFFFFFF_FFFFFFEB; busy high for exactly 34 cycles.
- MULTU a=b=0xFFFFFFFF -> result=0xFFFFFFFE_00000001.
- Divide cases:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFF_FFFFFFFD.
  - DIVU a=100, b=7 -> result=0x00000002_0000000E.
- Edge cases:
  - DIVU a=0x1234, b=0 -> result=0x00001234_FFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> result=0x00000000_80000000.
- Interference:
  - Second start with different operands at E0+5 -> ignored; first result is unchanged.
  - Back-to-back start in the done cycle -> second done at +34.
- Aborts:
  - flush at E0+10 -> busy=0 next cycle, no done, result keeps its prior value.
  - rst=0 asynchronously at E0+20 -> busy, done and result go to 0 immediately; a new op after release completes correctly.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
//
// One operation runs at a time and walks through four states.
//   IDLE  captures the operands.
//   PREP  forms the magnitudes and records the signs.
//   RUN   does 32 radix-2 steps.
//   FIX   applies the sign corrections.
// Accepting a start at edge E0 gives a done pulse in the cycle after E34.
// The result is {HI, LO}: bits 63:32 go to HI and bits 31:0 go to LO.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   request a new operation; only accepted in IDLE
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a       rs operand: multiplicand or dividend (sampled with start)
//   b       rt operand: multiplier or divisor (sampled with start)
//   flush   abort any in-flight operation; no done is produced
//   busy    registered; high in every state except IDLE
//   stall   combinational busy | (start & ~busy)
//   done    registered one-cycle pulse; result is valid while high
//   result  registered {HI, LO}; holds its value between done pulses

module mdu_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] ma_q, ma_d;       // |a|: multiplicand, or dividend shifted out MSB first
    logic [31:0] mb_q, mb_d;       // |b|: multiplier shifted out LSB first, or divisor
    logic [63:0] acc_q, acc_d;     // product, or {remainder, quotient} while dividing
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] result_q, result_d;

    logic        is_div;
    logic        is_signed;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_qbit;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // Shift-add step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign mul_sum = {1'b0, acc_q[63:32]} + (mb_q[0] ? {1'b0, ma_q} : 33'd0);

    // Restoring step: bring in the next dividend bit and trial-subtract the divisor.
    // A clear borrow bit means the subtraction fits, so the quotient bit is 1.
    assign div_shift = {acc_q[63:32], ma_q[31]};
    assign div_diff  = div_shift - {1'b0, mb_q};
    assign div_qbit  = ~div_diff[32];

    assign quo_fix  = neg_quo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    assign prod_fix = neg_quo_q ? (64'd0 - acc_q)        : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = StPrep;
                end
            end

            StPrep: begin
                ma_d      = (is_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
                mb_d      = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
                neg_quo_d = is_signed & (a_q[31] ^ b_q[31]);
                neg_rem_d = is_signed & a_q[31];
                acc_d     = 64'd0;
                cnt_d     = 5'd31;
                state_d   = StRun;
            end

            StRun: begin
                if (is_div) begin
                    acc_d[63:32] = div_qbit ? div_diff[31:0] : div_shift[31:0];
                    acc_d[31:0]  = {acc_q[30:0], div_qbit};
                    ma_d         = {ma_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                    mb_d  = {1'b0, mb_q[31:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            StFix: begin
                if (is_div) begin
                    // Divide by zero returns the raw dividend in HI and all ones in LO.
                    if (b_q == 32'd0) begin
                        result_d = {a_q, 32'hFFFF_FFFF};
                    end else begin
                        result_d = {rem_fix, quo_fix};
                    end
                end else begin
                    result_d = prod_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Flush overrides everything, including a start in the same cycle.
        if (flush) begin
            state_d  = StIdle;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            ma_q      <= 32'd0;
            mb_q      <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = busy_q | (start & ~busy_q);

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter against an arithmetic reference.

module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    mdu_iter u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain language arithmetic plus the two documented special cases.
    function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        int                 ix;
        int                 iy;
        int                 q;
        int                 r;
        case (o)
            2'b00: begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                return sx * sy;
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ix = x;
                iy = y;
                q  = ix / iy;
                r  = ix % iy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation starting in the current cycle and returns in its done cycle.
    // intf_at >= 0 drives a competing start with other operands that many cycles after E0.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int intf_at, input string tag);
        logic [63:0] exp;
        int          n;
        int          busy_n;
        int          stall_bad;
        exp   = ref_mdu(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        #1;
        check({tag, "_stall_start"}, 64'(stall), 64'd1);
        step();
        start     = 1'b0;
        n         = 0;
        busy_n    = 0;
        stall_bad = 0;
        while (!done && n < 100) begin
            if (busy) busy_n++;
            if (stall !== busy) stall_bad++;
            if (n == intf_at) begin
                start = 1'b1;
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd34);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_stall_at_done"}, 64'(stall), 64'd0);
        check({tag, "_stall_tracks_busy"}, 64'(stall_bad), 64'd0);
    endtask

    task automatic do_flush(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prev;
        int          done_n;
        prev  = result;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_next", 64'(busy), 64'd0);
        check("flush_done_next", 64'(done), 64'd0);
        done_n = 0;
        repeat (40) begin
            step();
            if (done) done_n++;
        end
        check("flush_no_done", 64'(done_n), 64'd0);
        check("flush_result_kept", result, prev);
        // Flush and start together: start must be dropped.
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_same_cycle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst = 1'b1;
        step();

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        check("mult_neg_const", result, 64'hFFFF_FFFF_FFFF_FFEB);
        step();
        check("done_pulse_width", 64'(done), 64'd0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max_const", result, 64'hFFFF_FFFE_0000_0001);
        step();
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        check("div_neg_const", result, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        do_op(2'b11, 32'd100, 32'd7, -1, "divu_small");
        check("divu_small_const", result, 64'h0000_0002_0000_000E);
        step();
        do_op(2'b11, 32'h0000_1234, 32'd0, -1, "divu_zero");
        check("divu_zero_const", result, 64'h0000_1234_FFFF_FFFF);
        step();
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf_const", result, 64'h0000_0000_8000_0000);
        step();
        do_op(2'b10, 32'h8765_4321, 32'd0, -1, "div_zero_signed");
        step();

        do_op(2'b11, 32'd1000, 32'd33, 5, "interfere");

        // Back-to-back: the second start lands in the first op's done cycle.
        do_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, -1, "b2b_first");
        do_op(2'b10, 32'hDEAD_BEEF, 32'd12345, -1, "b2b_second");
        step();

        do_flush(2'b01, 32'hCAFE_F00D, 32'h1357_9BDF);

        // Asynchronous reset mid-operation.
        op    = 2'b00;
        a     = 32'h0BAD_CAFE;
        b     = 32'h7777_7777;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        check("async_reset_result", result, 64'd0);
        #1;
        rst = 1'b1;
        do_op(2'b10, 32'hFFFF_FF00, 32'd9, -1, "after_reset");
        step();

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, -1, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
